// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser slice.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_OP,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_CHK,
    S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CHK,
    ERR_OP,
    ERR_TIMEOUT
  } err_code_t;

  localparam logic [7:0]  OP_WR_REG  = 8'h01;
  localparam logic [7:0]  OP_RD_REG  = 8'h02;
  localparam logic [7:0]  OP_ARM     = 8'h03;
  localparam logic [7:0]  OP_CLR_CAP = 8'h04;
  localparam int unsigned FRAME_LEN  = 6;

  // Legal opcodes are 1..num_ops inclusive.
  function automatic logic op_legal(input logic [7:0] op, input int unsigned num_ops);
    return (op != 8'h00) && (32'(op) <= num_ops);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// RX byte input, command handshake and error reporting of the command parser.
interface uart_cmd_parser_if;
  logic        data_rdy;
  logic [7:0]  data_received;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        err_valid;
  logic [1:0]  err_code;
  logic        busy;

  // The parser itself.
  modport slave (
    input  data_rdy, data_received, cmd_ready,
    output cmd_valid, cmd_op, cmd_addr, cmd_data, err_valid, err_code, busy
  );

  // RX path plus command consumer.
  modport master (
    output data_rdy, data_received, cmd_ready,
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, err_valid, err_code, busy
  );
endinterface

// File: rtl/uart_rdy_sync.sv
// Two-flop synchroniser for an asynchronous level plus rising-edge strobe.
module uart_rdy_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic input_clk,
  input  logic reset,
  input  logic async_in,
  output logic strobe
);
  logic meta_q, sync_q, prev_q;

  // All three flops share the reset value so a level already present at
  // reset release cannot look like a fresh edge.
  always_ff @(posedge input_clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign strobe = sync_q & ~prev_q;
endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 6-byte SYNC/OP/ADDR/DHI/DLO/CHK frames from the UART RX byte
// stream and presents validated commands on a valid/ready handshake.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter int unsigned NUM_OPS        = 4
) (
  input logic              input_clk,
  input logic              reset,
  uart_cmd_parser_if.slave bus
);
  localparam int unsigned  CNT_W   = $clog2(TIMEOUT_CYCLES);
  // Firing when the count is about to reach TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic             byte_stb;
  logic             byte_vld_q;
  logic [7:0]       byte_q;
  state_t           state_q;
  logic [7:0]       op_q, addr_q, dhi_q, dlo_q, xor_q;
  logic             cmd_valid_q;
  logic [7:0]       cmd_op_q, cmd_addr_q;
  logic [15:0]      cmd_data_q;
  logic             err_valid_q;
  err_code_t        err_code_q;
  logic [CNT_W-1:0] to_cnt_q;
  logic             idle_state;
  logic             timeout_hit;

  uart_rdy_sync #(
    .RESET_VAL (1'b1)
  ) u_rdy_sync (
    .input_clk (input_clk),
    .reset     (reset),
    .async_in  (bus.data_rdy),
    .strobe    (byte_stb)
  );

  // Capture the RX byte on the strobe; byte_vld_q marks it for the FSM.
  always_ff @(posedge input_clk) begin
    if (reset) begin
      byte_q     <= 8'h00;
      byte_vld_q <= 1'b0;
    end else begin
      byte_vld_q <= byte_stb;
      if (byte_stb) byte_q <= bus.data_received;
    end
  end

  assign idle_state  = (state_q == S_SYNC) || (state_q == S_HOLD);
  // A byte in flight always beats the timeout.
  assign timeout_hit = !idle_state && !byte_stb && !byte_vld_q && (to_cnt_q == TO_LAST);

  // Frame FSM, checksum accumulator, timeout counter and registered outputs.
  always_ff @(posedge input_clk) begin
    if (reset) begin
      state_q     <= S_SYNC;
      op_q        <= 8'h00;
      addr_q      <= 8'h00;
      dhi_q       <= 8'h00;
      dlo_q       <= 8'h00;
      xor_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 8'h00;
      cmd_addr_q  <= 8'h00;
      cmd_data_q  <= 16'h0000;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      to_cnt_q    <= '0;
    end else begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;

      if (byte_stb || idle_state) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != '1) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end

      if (timeout_hit) begin
        state_q     <= S_SYNC;
        err_valid_q <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
      end else begin
        unique case (state_q)
          S_SYNC: begin
            if (byte_vld_q && byte_q == SYNC_BYTE) begin
              xor_q   <= 8'h00;
              state_q <= S_OP;
            end
          end
          S_OP: begin
            if (byte_vld_q) begin
              op_q    <= byte_q;
              xor_q   <= byte_q;
              state_q <= S_ADDR;
            end
          end
          S_ADDR: begin
            if (byte_vld_q) begin
              addr_q  <= byte_q;
              xor_q   <= xor_q ^ byte_q;
              state_q <= S_DHI;
            end
          end
          S_DHI: begin
            if (byte_vld_q) begin
              dhi_q   <= byte_q;
              xor_q   <= xor_q ^ byte_q;
              state_q <= S_DLO;
            end
          end
          S_DLO: begin
            if (byte_vld_q) begin
              dlo_q   <= byte_q;
              xor_q   <= xor_q ^ byte_q;
              state_q <= S_CHK;
            end
          end
          S_CHK: begin
            if (byte_vld_q) begin
              if (byte_q != xor_q) begin
                err_valid_q <= 1'b1;
                err_code_q  <= ERR_CHK;
                state_q     <= S_SYNC;
              end else if (op_legal(op_q, NUM_OPS)) begin
                cmd_valid_q <= 1'b1;
                cmd_op_q    <= op_q;
                cmd_addr_q  <= addr_q;
                cmd_data_q  <= {dhi_q, dlo_q};
                state_q     <= S_HOLD;
              end else begin
                err_valid_q <= 1'b1;
                err_code_q  <= ERR_OP;
                state_q     <= S_SYNC;
              end
            end
          end
          S_HOLD: begin
            // Incoming bytes are ignored until the command is taken.
            if (cmd_valid_q && bus.cmd_ready) begin
              cmd_valid_q <= 1'b0;
              state_q     <= S_SYNC;
            end
          end
          default: state_q <= S_SYNC;
        endcase
      end
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_op    = cmd_op_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.cmd_data  = cmd_data_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
  assign bus.busy      = (state_q != S_SYNC) || cmd_valid_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser.
module tb_uart_cmd_parser;
  logic input_clk = 1'b0;
  logic reset     = 1'b1;
  int   checks    = 0;
  int   failures  = 0;

  // Event tallies kept by the negedge monitor; tests compare deltas.
  int          valid_cycles = 0;
  int          acc_cnt      = 0;
  int          err_cnt      = 0;
  int          code_stuck   = 0;
  logic [1:0]  last_err     = 2'd0;
  logic [7:0]  acc_op       = 8'h00;
  logic [7:0]  acc_addr     = 8'h00;
  logic [15:0] acc_data     = 16'h0000;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(
    .TIMEOUT_CYCLES (50)
  ) dut (
    .input_clk (input_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 input_clk = ~input_clk;

  always @(negedge input_clk) begin
    if (bus.cmd_valid) valid_cycles++;
    if (bus.cmd_valid && bus.cmd_ready) begin
      acc_cnt++;
      acc_op   = bus.cmd_op;
      acc_addr = bus.cmd_addr;
      acc_data = bus.cmd_data;
    end
    if (bus.err_valid) begin
      err_cnt++;
      last_err = bus.err_code;
    end
    if (!bus.err_valid && bus.err_code != 2'd0) code_stuck++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge input_clk); #1;
    bus.data_received = b;
    bus.data_rdy      = 1'b1;
    repeat (4) @(posedge input_clk);
    #1 bus.data_rdy = 1'b0;
    repeat (3) @(posedge input_clk);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [7:0] dhi, input logic [7:0] dlo,
                            input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(addr);
    send_byte(dhi);
    send_byte(dlo);
    send_byte(chk);
    repeat (4) @(posedge input_clk);
  endtask

  task automatic test_reset;
    // data_rdy already high across reset release must not yield a byte.
    reset             = 1'b1;
    bus.data_rdy      = 1'b1;
    bus.data_received = 8'hA5;
    bus.cmd_ready     = 1'b0;
    repeat (3) @(posedge input_clk);
    #1;
    checks++;
    if ({bus.cmd_valid, bus.err_valid, bus.err_code, bus.busy, bus.cmd_op, bus.cmd_addr,
         bus.cmd_data} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b err=%b code=%0d busy=%b op=%h addr=%h data=%h, want all 0",
               bus.cmd_valid, bus.err_valid, bus.err_code, bus.busy, bus.cmd_op, bus.cmd_addr,
               bus.cmd_data);
    end
    reset = 1'b0;
    repeat (10) @(posedge input_clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_high: busy=%b, want 0 (no strobe from pre-high data_rdy)", bus.busy);
    end
    bus.data_rdy = 1'b0;
    repeat (5) @(posedge input_clk);
  endtask

  task automatic test_good_frame;
    int e0;
    int a0;
    e0 = err_cnt;
    a0 = acc_cnt;
    bus.cmd_ready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h12);
    send_byte(8'h34);
    // Last byte: valid expected 4 edges after data_rdy rises, for one cycle.
    @(posedge input_clk); #1;
    bus.data_received = 8'h37;
    bus.data_rdy      = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge input_clk); #1;
      checks++;
      if (bus.cmd_valid !== (i == 4)) begin
        failures++;
        $display("FAIL good_latency[%0d]: cmd_valid=%b, want %b", i, bus.cmd_valid, (i == 4));
      end
    end
    bus.data_rdy = 1'b0;
    repeat (5) @(posedge input_clk);
    #1;
    checks++;
    if (acc_cnt - a0 !== 1 || acc_op !== 8'h01 || acc_addr !== 8'h10 || acc_data !== 16'h1234
        || err_cnt - e0 !== 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL good_frame: acc=%0d op=%h addr=%h data=%h errs=%0d busy=%b, want 1 01 10 1234 0 0",
               acc_cnt - a0, acc_op, acc_addr, acc_data, err_cnt - e0, bus.busy);
    end
  endtask

  task automatic test_chk_err;
    int e0;
    int v0;
    int a0;
    e0 = err_cnt;
    v0 = valid_cycles;
    bus.cmd_ready = 1'b1;
    send_frame(8'h02, 8'h20, 8'h00, 8'h00, 8'hFF);
    checks++;
    if (err_cnt - e0 !== 1 || last_err !== 2'd1 || valid_cycles - v0 !== 0) begin
      failures++;
      $display("FAIL chk_err: err_cycles=%0d code=%0d valid_cycles=%0d, want 1 1 0",
               err_cnt - e0, last_err, valid_cycles - v0);
    end
    a0 = acc_cnt;
    send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
    checks++;
    if (acc_cnt - a0 !== 1 || acc_data !== 16'h1234) begin
      failures++;
      $display("FAIL chk_recover: accepted=%0d data=%h, want 1 1234", acc_cnt - a0, acc_data);
    end
  endtask

  task automatic test_op_err;
    int e0;
    int v0;
    e0 = err_cnt;
    v0 = valid_cycles;
    send_frame(8'h07, 8'h00, 8'h00, 8'h00, 8'h07);
    checks++;
    if (err_cnt - e0 !== 1 || last_err !== 2'd2 || valid_cycles - v0 !== 0) begin
      failures++;
      $display("FAIL op_err: err_cycles=%0d code=%0d valid_cycles=%0d, want 1 2 0",
               err_cnt - e0, last_err, valid_cycles - v0);
    end
  endtask

  task automatic test_timeout;
    int         first;
    logic [1:0] code;
    int         a0;
    first = 0;
    code  = 2'd0;
    bus.cmd_ready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h01);
    @(posedge input_clk); #1;
    bus.data_received = 8'h10;
    bus.data_rdy      = 1'b1;
    // Strobe is sampled on edge 3; the error shows 49 edges after that.
    for (int n = 1; n <= 80; n++) begin
      @(posedge input_clk); #1;
      if (n == 4) bus.data_rdy = 1'b0;
      if (n == 40) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL timeout_busy: busy=%b mid-frame, want 1", bus.busy);
        end
      end
      if (bus.err_valid && first == 0) begin
        first = n;
        code  = bus.err_code;
      end
    end
    checks++;
    if (first !== 52 || code !== 2'd3) begin
      failures++;
      $display("FAIL timeout_err: first err at edge %0d code=%0d, want edge 52 code 3", first, code);
    end
    a0 = acc_cnt;
    send_frame(8'h03, 8'h00, 8'h00, 8'h00, 8'h03);
    checks++;
    if (acc_cnt - a0 !== 1 || acc_op !== 8'h03) begin
      failures++;
      $display("FAIL timeout_recover: accepted=%0d op=%h, want 1 03", acc_cnt - a0, acc_op);
    end
  endtask

  task automatic test_hold;
    int bad;
    int a0;
    bad = 0;
    a0  = acc_cnt;
    bus.cmd_ready = 1'b0;
    send_frame(8'h04, 8'hAB, 8'hCD, 8'hEF, 8'h8D);
    for (int i = 0; i < 20; i++) begin
      @(posedge input_clk); #1;
      if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 8'h04 || bus.cmd_addr !== 8'hAB
          || bus.cmd_data !== 16'hCDEF || bus.busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_stable: %0d unstable cycles, want 0 (op=%h addr=%h data=%h)",
               bad, bus.cmd_op, bus.cmd_addr, bus.cmd_data);
    end
    bus.cmd_ready = 1'b1;
    @(posedge input_clk); #1;
    checks++;
    if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0 || acc_cnt - a0 !== 1) begin
      failures++;
      $display("FAIL hold_release: valid=%b busy=%b accepted=%0d, want 0 0 1",
               bus.cmd_valid, bus.busy, acc_cnt - a0);
    end
  endtask

  task automatic test_reset_mid;
    int e0;
    int a0;
    bus.cmd_ready = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    @(posedge input_clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge input_clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_valid !== 1'b0 || bus.err_valid !== 1'b0
        || bus.err_code !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: busy=%b valid=%b err=%b code=%0d, want 0",
               bus.busy, bus.cmd_valid, bus.err_valid, bus.err_code);
    end
    reset = 1'b0;
    e0 = err_cnt;
    a0 = acc_cnt;
    send_frame(8'h02, 8'h55, 8'h0F, 8'hF0, 8'hA8);
    checks++;
    if (acc_cnt - a0 !== 1 || acc_op !== 8'h02 || acc_addr !== 8'h55 || acc_data !== 16'h0FF0
        || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL reset_mid_decode: acc=%0d op=%h addr=%h data=%h errs=%0d, want 1 02 55 0ff0 0",
               acc_cnt - a0, acc_op, acc_addr, acc_data, err_cnt - e0);
    end
  endtask

  task automatic test_reset_hold;
    int a0;
    bus.cmd_ready = 1'b0;
    send_frame(8'h01, 8'h00, 8'h00, 8'h01, 8'h00);
    a0 = acc_cnt;
    @(posedge input_clk); #1;
    reset = 1'b1;
    @(posedge input_clk); #1;
    reset = 1'b0;
    checks++;
    if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: valid=%b busy=%b after reset, want 0 0", bus.cmd_valid, bus.busy);
    end
    bus.cmd_ready = 1'b1;
    repeat (5) @(posedge input_clk);
    #1;
    checks++;
    if (acc_cnt - a0 !== 0) begin
      failures++;
      $display("FAIL reset_hold_lost: accepted=%0d, want 0", acc_cnt - a0);
    end
  endtask

  task automatic test_sync_in_data;
    int e0;
    int a0;
    e0 = err_cnt;
    a0 = acc_cnt;
    bus.cmd_ready = 1'b1;
    send_byte(8'h33);
    send_frame(8'h01, 8'hA5, 8'h00, 8'h00, 8'hA4);
    checks++;
    if (acc_cnt - a0 !== 1 || acc_addr !== 8'hA5 || err_cnt - e0 !== 0) begin
      failures++;
      $display("FAIL sync_in_data: acc=%0d addr=%h errs=%0d, want 1 a5 0",
               acc_cnt - a0, acc_addr, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back;
    int a0;
    a0 = acc_cnt;
    bus.cmd_ready = 1'b1;
    send_frame(8'h03, 8'h01, 8'h00, 8'h01, 8'h03);
    send_frame(8'h04, 8'h02, 8'hBE, 8'hEF, 8'h57);
    checks++;
    if (acc_cnt - a0 !== 2 || acc_op !== 8'h04 || acc_data !== 16'hBEEF) begin
      failures++;
      $display("FAIL back_to_back: acc=%0d op=%h data=%h, want 2 04 beef",
               acc_cnt - a0, acc_op, acc_data);
    end
    checks++;
    if (code_stuck !== 0) begin
      failures++;
      $display("FAIL err_code_idle: %0d cycles with code!=0 and no err_valid, want 0", code_stuck);
    end
  endtask

  initial begin
    bus.data_rdy      = 1'b0;
    bus.data_received = 8'h00;
    bus.cmd_ready     = 1'b0;
    test_reset();
    test_good_frame();
    test_chk_err();
    test_op_err();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_reset_hold();
    test_sync_in_data();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
